// File: rtl/nn_request_scheduler.sv
// nn_request_scheduler: round-robin sharing of one neural_network between clients,
// with an in-order tag FIFO routing each result back to its issuer, plus flush/drain.
module nn_request_scheduler #(
    parameter int NUM_REQUESTERS    = 4,
    parameter int NUM_DATA_INPUTS   = 2,
    parameter int INPUT_DATA_WIDTH  = 16,
    parameter int NUM_DATA_OUTPUTS  = 1,
    parameter int OUTPUT_DATA_WIDTH = 10,
    parameter int MAX_IN_FLIGHT     = 8
) (
    input  logic                                                                    ap_clk,
    input  logic                                                                    ap_rst,
    input  logic [NUM_REQUESTERS-1:0]                                               req_valid,
    input  logic [NUM_REQUESTERS-1:0][NUM_DATA_INPUTS-1:0][INPUT_DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQUESTERS-1:0]                                               req_ready,
    output logic                                                                    nn_start,
    output logic [NUM_DATA_INPUTS-1:0][INPUT_DATA_WIDTH-1:0]                        nn_data_in,
    input  logic                                                                    nn_ready,
    input  logic                                                                    nn_data_out_valid,
    input  logic [NUM_DATA_OUTPUTS-1:0][OUTPUT_DATA_WIDTH-1:0]                      nn_data_out,
    output logic [NUM_REQUESTERS-1:0]                                               resp_valid,
    output logic [NUM_DATA_OUTPUTS-1:0][OUTPUT_DATA_WIDTH-1:0]                      resp_data,
    input  logic                                                                    flush_req,
    output logic                                                                    flush_done,
    output logic [$clog2(MAX_IN_FLIGHT+1)-1:0]                                      in_flight,
    output logic                                                                    err_orphan
);
    localparam int IW = $clog2(NUM_REQUESTERS);
    localparam int FW = $clog2(MAX_IN_FLIGHT);
    localparam int CW = $clog2(MAX_IN_FLIGHT+1);

    typedef enum logic [1:0] {RUN, DRAIN, FLUSHED} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] rr_ptr, grant, idx;
    logic          any_valid, issue, fire, pop;
    logic [IW-1:0] tags [MAX_IN_FLIGHT];
    logic [FW-1:0] wr_ptr, rd_ptr;

    // Scan downward so the lowest offset from the pointer wins
    always_comb begin
        grant = '0;
        idx = '0;
        any_valid = 1'b0;
        for (int i = NUM_REQUESTERS-1; i >= 0; i--) begin
            idx = IW'((int'(rr_ptr) + i) % NUM_REQUESTERS);
            if (req_valid[idx]) begin
                grant = idx;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = (state == RUN && flush_req) ? DRAIN :
                   (state == DRAIN && in_flight == '0) ? FLUSHED :
                   (state == FLUSHED && !flush_req) ? RUN : state;
    end

    assign issue      = !ap_rst && state == RUN && any_valid && in_flight < CW'(MAX_IN_FLIGHT);
    assign fire       = issue && nn_ready;
    assign pop        = nn_data_out_valid && in_flight != '0;
    assign nn_start   = issue;
    assign nn_data_in = issue ? req_data[grant] : '0;
    assign req_ready  = fire ? (NUM_REQUESTERS'(1) << grant) : '0;
    assign flush_done = state == FLUSHED;

    always_ff @(posedge ap_clk)
        if (fire) tags[wr_ptr] <= grant;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state      <= RUN;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            in_flight  <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            err_orphan <= 1'b0;
        end else begin
            state <= state_nx;
            if (fire) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (grant == IW'(NUM_REQUESTERS-1)) ? '0 : grant + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                resp_data <= nn_data_out;
            end
            in_flight  <= in_flight + CW'(fire) - CW'(pop);
            resp_valid <= pop ? (NUM_REQUESTERS'(1) << tags[rd_ptr]) : '0;
            if (nn_data_out_valid && !pop) err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_nn_request_scheduler.sv
// tb_nn_request_scheduler: directed stimulus with grant/response scoreboards for
// nn_request_scheduler; monitors compare at the falling edge.
module tb_nn_request_scheduler;
    localparam int NR = 4, NI = 2, IWD = 16, NO = 1, OWD = 10, MIF = 8;

    logic                            ap_clk = 1'b0, ap_rst = 1'b0;
    logic [NR-1:0]                   req_valid = '0;
    logic [NR-1:0][NI-1:0][IWD-1:0]  req_data;
    logic [NR-1:0]                   req_ready;
    logic                            nn_start;
    logic [NI-1:0][IWD-1:0]          nn_data_in;
    logic                            nn_ready = 1'b0, nn_data_out_valid = 1'b0, flush_req = 1'b0;
    logic [NO-1:0][OWD-1:0]          nn_data_out = '0;
    logic [NR-1:0]                   resp_valid;
    logic [NO-1:0][OWD-1:0]          resp_data;
    logic                            flush_done, err_orphan;
    logic [$clog2(MIF+1)-1:0]        in_flight;

    int checks = 0, passes = 0;
    logic [NR+OWD-1:0] exp_resp [$];
    int                exp_grant [$];
    logic [NR+OWD-1:0] e_resp;
    int                e_id;

    nn_request_scheduler #(
        .NUM_REQUESTERS(NR), .NUM_DATA_INPUTS(NI), .INPUT_DATA_WIDTH(IWD),
        .NUM_DATA_OUTPUTS(NO), .OUTPUT_DATA_WIDTH(OWD), .MAX_IN_FLIGHT(MIF)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .nn_start(nn_start), .nn_data_in(nn_data_in),
        .nn_ready(nn_ready), .nn_data_out_valid(nn_data_out_valid), .nn_data_out(nn_data_out),
        .resp_valid(resp_valid), .resp_data(resp_data), .flush_req(flush_req),
        .flush_done(flush_done), .in_flight(in_flight), .err_orphan(err_orphan)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic logic [NI-1:0][IWD-1:0] din(int c);
        return {16'h2000 + 16'(c), 16'h1000 + 16'(c)};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic push_resp(int id, logic [OWD-1:0] d);
        exp_resp.push_back({NR'(1) << id, d});
    endtask

    always @(negedge ap_clk) begin
        if (resp_valid != '0) begin
            if (exp_resp.size() == 0) chk("resp_unexpected", 64'(resp_valid), 64'(0));
            else begin
                e_resp = exp_resp.pop_front();
                chk("resp", 64'({resp_valid, resp_data}), 64'(e_resp));
            end
        end
        if (req_ready != '0) begin
            if (exp_grant.size() == 0) chk("grant_unexpected", 64'(req_ready), 64'(0));
            else begin
                e_id = exp_grant.pop_front();
                chk("grant_ready", 64'(req_ready), 64'(NR'(1) << e_id));
                chk("grant_data", 64'(nn_data_in), 64'(din(e_id)));
            end
        end
    end

    initial begin
        for (int c = 0; c < NR; c++) req_data[c] = din(c);
        #1 ap_rst = 1'b1;
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_nn_start", 64'(nn_start), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_data", 64'(resp_data), 64'(0));
        chk("rst_flush_done", 64'(flush_done), 64'(0));
        chk("rst_in_flight", 64'(in_flight), 64'(0));
        chk("rst_err_orphan", 64'(err_orphan), 64'(0));
        tick();
        ap_rst = 1'b0;
        // Round-robin over all four clients
        req_valid = 4'b1111;
        nn_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_grant.push_back(i);
        repeat (4) tick();
        nn_ready = 1'b0;
        #1;
        chk("rr_in_flight", 64'(in_flight), 64'(4));
        chk("rr_ptr_wrap_start", 64'(nn_start), 64'(1));
        chk("rr_ptr_wrap_data", 64'(nn_data_in), 64'(din(0)));
        chk("rr_no_ready", 64'(req_ready), 64'(0));
        req_valid = '0;
        nn_data_out_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nn_data_out = OWD'(10'h101 + i);
            push_resp(i, OWD'(10'h101 + i));
            tick();
        end
        nn_data_out_valid = 1'b0;
        #1 chk("rr_drained", 64'(in_flight), 64'(0));
        tick();
        tick();
        chk("resp_data_hold", 64'(resp_data), 64'(10'h104));
        chk("resp_valid_idle", 64'(resp_valid), 64'(0));
        // Routing: clients 2 then 0
        req_valid = 4'b0100;
        nn_ready = 1'b1;
        exp_grant.push_back(2);
        tick();
        req_valid = 4'b0001;
        exp_grant.push_back(0);
        tick();
        req_valid = '0;
        nn_ready = 1'b0;
        nn_data_out_valid = 1'b1;
        nn_data_out = 10'h155;
        push_resp(2, 10'h155);
        tick();
        nn_data_out = 10'h0AA;
        push_resp(0, 10'h0AA);
        #1;
        chk("route1_valid", 64'(resp_valid), 64'(4'b0100));
        chk("route1_data", 64'(resp_data), 64'(10'h155));
        tick();
        nn_data_out_valid = 1'b0;
        #1;
        chk("route2_valid", 64'(resp_valid), 64'(4'b0001));
        chk("route2_data", 64'(resp_data), 64'(10'h0AA));
        tick();
        chk("route_strobe_one_cycle", 64'(resp_valid), 64'(0));
        // Flush with three outstanding
        req_valid = 4'b1111;
        nn_ready = 1'b1;
        for (int i = 1; i < 4; i++) exp_grant.push_back(i);
        repeat (3) tick();
        req_valid = '0;
        flush_req = 1'b1;
        tick();
        req_valid = 4'b1111;
        #1;
        chk("drain_no_issue", 64'(nn_start), 64'(0));
        chk("drain_no_ready", 64'(req_ready), 64'(0));
        chk("drain_not_done", 64'(flush_done), 64'(0));
        chk("drain_in_flight", 64'(in_flight), 64'(3));
        nn_data_out_valid = 1'b1;
        for (int i = 1; i < 4; i++) begin
            nn_data_out = OWD'(10'h011 * i);
            push_resp(i, OWD'(10'h011 * i));
            tick();
        end
        nn_data_out_valid = 1'b0;
        #1;
        chk("drain_empty", 64'(in_flight), 64'(0));
        chk("drain_done_late", 64'(flush_done), 64'(0));
        tick();
        chk("flushed_done", 64'(flush_done), 64'(1));
        chk("flushed_no_issue", 64'(nn_start), 64'(0));
        flush_req = 1'b0;
        req_valid = '0;
        tick();
        chk("flush_exit", 64'(flush_done), 64'(0));
        // Fill the tag FIFO
        req_valid = 4'b1111;
        nn_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_grant.push_back(i % 4);
        repeat (8) tick();
        #1;
        chk("full_in_flight", 64'(in_flight), 64'(8));
        chk("full_no_ready", 64'(req_ready), 64'(0));
        chk("full_no_start", 64'(nn_start), 64'(0));
        nn_data_out_valid = 1'b1;
        nn_data_out = 10'h3C0;
        push_resp(0, 10'h3C0);
        tick();
        nn_data_out_valid = 1'b0;
        req_valid = '0;
        #1 chk("full_return_no_fire", 64'(in_flight), 64'(7));
        // Async reset mid-cycle with work outstanding
        @(negedge ap_clk);
        #2;
        ap_rst = 1'b1;
        req_valid = 4'b1111;
        nn_ready = 1'b1;
        #1;
        chk("arst_req_ready", 64'(req_ready), 64'(0));
        chk("arst_nn_start", 64'(nn_start), 64'(0));
        chk("arst_nn_data_in", 64'(nn_data_in), 64'(0));
        chk("arst_resp_valid", 64'(resp_valid), 64'(0));
        chk("arst_resp_data", 64'(resp_data), 64'(0));
        chk("arst_in_flight", 64'(in_flight), 64'(0));
        chk("arst_flush_done", 64'(flush_done), 64'(0));
        tick();
        ap_rst = 1'b0;
        req_valid = '0;
        nn_ready = 1'b0;
        // Result with no outstanding tag
        nn_data_out_valid = 1'b1;
        nn_data_out = 10'h2AB;
        tick();
        nn_data_out_valid = 1'b0;
        #1;
        chk("orphan_set", 64'(err_orphan), 64'(1));
        chk("orphan_no_resp", 64'(resp_valid), 64'(0));
        chk("orphan_in_flight", 64'(in_flight), 64'(0));
        tick();
        tick();
        chk("orphan_sticky", 64'(err_orphan), 64'(1));
        chk("orphan_resp_data", 64'(resp_data), 64'(0));
        tick();
        chk("resp_queue_empty", 64'(exp_resp.size()), 64'(0));
        chk("grant_queue_empty", 64'(exp_grant.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
